handshake_window_monitor: RTL and testbench
===========================================

// Module: handshake_window_monitor
// PURPOSE
//  Synthesizable multi-channel req/ack latency checker; successor to the generated per-edge SVA checks.
//  Each channel measures the cycles from a req rising edge to the first ack sample and flags early, late and dropped handshakes.
//  It keeps saturating per-channel violation counters and a sticky summary flag.
//  Sits beside bus/handshake interfaces in simulation and in silicon debug builds.
// PARAMETERS
//  NUM_CH   4   number of independent req/ack channels (>=1)
//  MIN_DLY  1   minimum legal req-rise-to-ack latency, cycles (>=0)
//  MAX_DLY  5   maximum legal latency, cycles (>=MIN_DLY, >=1); elaboration error otherwise
//  CNT_W    8   width of each per-channel violation counter
//  LAT_W    $clog2(MAX_DLY+2)   derived (localparam): width of latency timer and last_lat fields
// PORTS
//  clk        in   1             clock, all logic on posedge
//  rst        in   1             synchronous active-high reset
//  enable     in   1             1 = monitoring active; 0 = ignore new req edges, abort pending channels
//  clear      in   1             1-cycle clear of viol_cnt and any_viol
//  req        in   NUM_CH        per-channel request
//  ack        in   NUM_CH        per-channel acknowledge
//  busy       out  NUM_CH        channel is in WAIT (timing a handshake)
//  viol_early out  NUM_CH        1-cycle pulse: ack arrived with latency < MIN_DLY
//  viol_late  out  NUM_CH        1-cycle pulse: no ack by latency MAX_DLY
//  viol_drop  out  NUM_CH        1-cycle pulse: req fell before any ack
//  last_lat   out  NUM_CH*LAT_W  latency of most recent acked handshake, ch i at [i*LAT_W +: LAT_W]
//  viol_cnt   out  NUM_CH*CNT_W  saturating violation count per channel, ch i at [i*CNT_W +: CNT_W]
//  any_viol   out  1             sticky OR of all violations since reset/clear
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0, all channels IDLE, timers 0; req_q loads 1 so req held high across reset is not a rise.
//  Rise: req[i]=1 and req_q[i]=0 at posedge T. Latency L = posedge index of ack sample minus T (ack=1 at T gives L=0).
//  Per-channel FSM, IDLE/WAIT:
//   IDLE -> WAIT: rise seen and enable=1; same-sample ack evaluated immediately as L=0 (no WAIT entry if acked).
//   WAIT, ack=1: MIN_DLY<=L<=MAX_DLY -> pass; L<MIN_DLY -> early. Either way last_lat<=L, back to IDLE.
//   WAIT, ack=0, req=0: drop, IDLE.
//   WAIT, ack=0, req=1, L==MAX_DLY+1: late, IDLE (so ack at L=MAX_DLY is a pass).
//   WAIT, enable=0: silent abort to IDLE, no flag, no count.
//  Priority within one sample: enable=0 abort > ack (pass/early) > drop > late; ack with req falling is not a drop.
//  Rise while WAIT is impossible (a drop must come first); a rise in the same sample a channel returns to IDLE is not started (next rise needed).
//  Rise with enable=0 ignored; raising enable while req is already high does not start timing.
//  Outputs registered: a flag detected on sample at posedge k is high for exactly the cycle after k; busy mirrors the state register.
//  Timer counts 0..MAX_DLY+1 only, never wraps; reset to 0 on every IDLE entry.
//  viol_cnt[i] += 1 on any violation of ch i (at most one per cycle); saturates at 2^CNT_W-1.
//  clear=1 zeroes viol_cnt and any_viol, winning over a same-cycle increment; it does not touch FSMs or last_lat.
//  any_viol sets the cycle after the first flag pulse; it stays set until clear or rst.
//  Channels are fully independent; simultaneous violations on several channels each count.
//  rst mid-handshake: channel returns to IDLE with no flag; a req still high after reset is not a new rise.
// TESTING
//  ch0 req rises at T, ack at T+3 (MIN=1, MAX=5) -> no flags; last_lat[0]=3; viol_cnt[0]=0.
//  ch1 req rises at T, ack at T (L=0) -> viol_early[1] pulses at T+1; viol_cnt[1]=1; any_viol=1.
//  ch2 req rises at T, held, no ack -> busy 6 cycles; viol_late[2] pulses once after sample T+6; ack at T+5 instead -> pass, last_lat=5.
//  ch3 req rises at T, falls at T+2, no ack -> viol_drop[3] one cycle; ack+req fall same sample -> pass.
//  CNT_W=2, 5 early violations on ch0 -> viol_cnt[0] saturates at 3; clear coincident with violation -> count 0.
//  rst or enable=0 pulse while ch0 busy -> busy drops, no flag, no count; held req after reset starts nothing.

Source files
------------

// File: rtl/handshake_window_monitor.sv
// Multi-channel req/ack latency checker: times each req rising edge to the first ack
// and flags early, late and dropped handshakes, with saturating per-channel counters.
module handshake_window_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 5,
    parameter int CNT_W   = 8,
    localparam int LAT_W  = $clog2(MAX_DLY + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         ack,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         viol_early,
    output logic [NUM_CH-1:0]         viol_late,
    output logic [NUM_CH-1:0]         viol_drop,
    output logic [NUM_CH*LAT_W-1:0]   last_lat,
    output logic [NUM_CH*CNT_W-1:0]   viol_cnt,
    output logic                      any_viol
);

    if (NUM_CH < 1 || MIN_DLY < 0 || MAX_DLY < 1 || MAX_DLY < MIN_DLY) begin : g_param_err
        $error("handshake_window_monitor: illegal NUM_CH/MIN_DLY/MAX_DLY combination");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [LAT_W-1:0] MIN_L  = LAT_W'(MIN_DLY);
    localparam logic [LAT_W-1:0] LATE_L = LAT_W'(MAX_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] req_q;
    logic              any_viol_q, any_viol_d;

    // req_q resets high so a req held across reset never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '1;
        end else begin
            req_q <= req;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [LAT_W-1:0] timer_q, timer_d;
        logic [LAT_W-1:0] lat_q, lat_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             early_q, early_d;
        logic             late_q, late_d;
        logic             drop_q, drop_d;
        logic             rise;

        assign rise = req[gi] & ~req_q[gi];

        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            lat_d   = lat_q;
            early_d = 1'b0;
            late_d  = 1'b0;
            drop_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise && enable) begin
                        if (ack[gi]) begin
                            lat_d   = '0;
                            early_d = (MIN_L != '0);
                        end else begin
                            // timer holds the latency the next sample will have
                            state_d = ST_WAIT;
                            timer_d = LAT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (ack[gi]) begin
                        lat_d   = timer_q;
                        early_d = (timer_q < MIN_L);
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (!req[gi]) begin
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer_q == LATE_L) begin
                        late_d  = 1'b1;
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + LAT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase

            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if ((early_d || late_d || drop_d) && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                lat_q   <= '0;
                cnt_q   <= '0;
                early_q <= 1'b0;
                late_q  <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                lat_q   <= lat_d;
                cnt_q   <= cnt_d;
                early_q <= early_d;
                late_q  <= late_d;
                drop_q  <= drop_d;
            end
        end

        assign busy[gi]                       = (state_q == ST_WAIT);
        assign viol_early[gi]                 = early_q;
        assign viol_late[gi]                  = late_q;
        assign viol_drop[gi]                  = drop_q;
        assign last_lat[gi*LAT_W +: LAT_W]    = lat_q;
        assign viol_cnt[gi*CNT_W +: CNT_W]    = cnt_q;
    end

    // Sticky summary follows the registered flag pulses, so it rises one cycle after them.
    always_comb begin
        any_viol_d = any_viol_q | (|viol_early) | (|viol_late) | (|viol_drop);
        if (clear) begin
            any_viol_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_viol_q <= 1'b0;
        end else begin
            any_viol_q <= any_viol_d;
        end
    end

    assign any_viol = any_viol_q;

endmodule

// File: tb/tb_handshake_window_monitor.sv
// Scoreboard bench for handshake_window_monitor (NUM_CH=4, MIN=1, MAX=5, CNT_W=2).
module tb_handshake_window_monitor;
    localparam int NCH  = 4;
    localparam int MIN  = 1;
    localparam int MAX  = 5;
    localparam int CW   = 2;
    localparam int LW   = 3;
    localparam int CMAX = 3;
    localparam int K_EARLY = 0;
    localparam int K_LATE  = 1;
    localparam int K_DROP  = 2;

    logic               clk = 1'b0;
    logic               rst, enable, clear;
    logic [NCH-1:0]     req, ack;
    logic [NCH-1:0]     busy, viol_early, viol_late, viol_drop;
    logic [NCH*LW-1:0]  last_lat;
    logic [NCH*CW-1:0]  viol_cnt;
    logic               any_viol;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt_m[NCH];

    typedef struct {
        int ch;
        int kind;
        int sample;
        int cnt;
    } exp_t;
    exp_t sb[$];

    handshake_window_monitor #(
        .NUM_CH (NCH),
        .MIN_DLY(MIN),
        .MAX_DLY(MAX),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .viol_early(viol_early),
        .viol_late (viol_late),
        .viol_drop (viol_drop),
        .last_lat  (last_lat),
        .viol_cnt  (viol_cnt),
        .any_viol  (any_viol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int c);
        return int'(last_lat[c*LW +: LW]);
    endfunction

    function automatic int cnt_of(int c);
        return int'(viol_cnt[c*CW +: CW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", nm, act, cyc);
        end
    endtask

    // Push the expected flag pulse seen 'off' samples from now; updates the counter model.
    task automatic expect_v(int ch, int kind, int off, bit clr);
        exp_t e;
        if (clr) cnt_m[ch] = 0;
        else if (cnt_m[ch] < CMAX) cnt_m[ch] = cnt_m[ch] + 1;
        e.ch = ch;
        e.kind = kind;
        e.sample = cyc + off;
        e.cnt = cnt_m[ch];
        sb.push_back(e);
    endtask

    // Monitor: every flag pulse must match the earliest pending expectation for its channel.
    always @(negedge clk) begin
        int idx;
        logic [2:0] f;
        logic [2:0] ef;
        for (int c = 0; c < NCH; c++) begin
            f = {viol_drop[c], viol_late[c], viol_early[c]};
            if (f != 3'b000) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].ch == c) idx = j;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_flag ch%0d: flags(drop,late,early)=%b, expected none (sample %0d)",
                             c, f, cyc);
                end else begin
                    ef = 3'b001 << sb[idx].kind;
                    if (f !== ef || cyc != sb[idx].sample || cnt_of(c) != sb[idx].cnt) begin
                        errors++;
                        $display("FAIL flag_ch%0d: flags=%b sample=%0d cnt=%0d, expected flags=%b sample=%0d cnt=%0d",
                                 c, f, cyc, cnt_of(c), ef, sb[idx].sample, sb[idx].cnt);
                    end else begin
                        $display("ok   flag_ch%0d flags=%b sample=%0d cnt=%0d", c, f, cyc, cnt_of(c));
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
        rst = 1'b1; enable = 1'b0; clear = 1'b0; req = 4'b0001; ack = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({viol_early, viol_late, viol_drop}), 64'd0);
        chk("rst_last_lat", 64'(last_lat), 64'd0);
        chk("rst_viol_cnt", 64'(viol_cnt), 64'd0);
        chk("rst_any_viol", 64'(any_viol), 64'd0);

        rst = 1'b0; enable = 1'b1;
        repeat (3) tick();
        chk("held_req_no_rise", 64'(busy), 64'd0);
        req = '0; tick();

        // ch0 pass at L=3
        req[0] = 1'b1; tick();
        chk("pass3_busy", 64'(busy[0]), 64'd1);
        tick(); tick();
        ack[0] = 1'b1; tick();
        chk("pass3_idle", 64'(busy[0]), 64'd0);
        chk("pass3_lat", 64'(lat_of(0)), 64'd3);
        chk("pass3_cnt", 64'(cnt_of(0)), 64'd0);
        req[0] = 1'b0; ack[0] = 1'b0; tick();

        // ch1 early at L=0
        req[1] = 1'b1; ack[1] = 1'b1; expect_v(1, K_EARLY, 1, 1'b0); tick();
        chk("early_no_wait", 64'(busy[1]), 64'd0);
        req[1] = 1'b0; ack[1] = 1'b0; repeat (2) tick();
        chk("early_cnt", 64'(cnt_of(1)), 64'(cnt_m[1]));
        chk("early_any_viol", 64'(any_viol), 64'd1);

        // ch2 late: busy for six cycles, flag after sample T+6
        req[2] = 1'b1; expect_v(2, K_LATE, 7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("late_busy", 64'(busy[2]), 64'd1);
        end
        tick();
        chk("late_idle", 64'(busy[2]), 64'd0);
        req[2] = 1'b0; tick();

        // ch2 pass at L=MAX
        req[2] = 1'b1; tick();
        repeat (4) tick();
        ack[2] = 1'b1; tick();
        chk("pass5_idle", 64'(busy[2]), 64'd0);
        chk("pass5_lat", 64'(lat_of(2)), 64'd5);
        req[2] = 1'b0; ack[2] = 1'b0; tick();

        // ch3 drop at L=2
        req[3] = 1'b1; tick(); tick();
        req[3] = 1'b0; expect_v(3, K_DROP, 1, 1'b0); tick();
        chk("drop_idle", 64'(busy[3]), 64'd0);
        tick();

        // ch3 ack with req falling in the same sample is a pass
        req[3] = 1'b1; tick(); tick();
        req[3] = 1'b0; ack[3] = 1'b1; tick();
        chk("ackfall_lat", 64'(lat_of(3)), 64'd2);
        chk("ackfall_cnt", 64'(cnt_of(3)), 64'(cnt_m[3]));
        ack[3] = 1'b0; tick();

        // ch1 pass at L=MIN
        req[1] = 1'b1; tick();
        ack[1] = 1'b1; tick();
        chk("pass1_lat", 64'(lat_of(1)), 64'd1);
        req[1] = 1'b0; ack[1] = 1'b0; tick();

        // simultaneous early on ch1 and ch2
        req[2:1] = 2'b11; ack[2:1] = 2'b11;
        expect_v(1, K_EARLY, 1, 1'b0); expect_v(2, K_EARLY, 1, 1'b0);
        tick();
        req = '0; ack = '0; tick();
        chk("simul_cnt1", 64'(cnt_of(1)), 64'(cnt_m[1]));
        chk("simul_cnt2", 64'(cnt_of(2)), 64'(cnt_m[2]));

        // ch0 saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            req[0] = 1'b1; ack[0] = 1'b1; expect_v(0, K_EARLY, 1, 1'b0); tick();
            req[0] = 1'b0; ack[0] = 1'b0; tick();
        end
        chk("sat_cnt0", 64'(cnt_of(0)), 64'd3);

        clear = 1'b1; tick();
        clear = 1'b0; tick();
        for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
        chk("clear_cnt", 64'(viol_cnt), 64'd0);
        chk("clear_any_viol", 64'(any_viol), 64'd0);

        // clear coincident with a violation wins
        req[1] = 1'b1; ack[1] = 1'b1; clear = 1'b1; expect_v(1, K_EARLY, 1, 1'b1); tick();
        clear = 1'b0; req[1] = 1'b0; ack[1] = 1'b0; tick();
        chk("clear_win_cnt", 64'(cnt_of(1)), 64'd0);
        clear = 1'b1; tick();
        clear = 1'b0; tick();
        chk("reclear_any_viol", 64'(any_viol), 64'd0);

        // enable=0 aborts a pending ch0 handshake silently; held req does not restart
        req[0] = 1'b1; tick(); tick();
        enable = 1'b0; tick();
        chk("abort_idle", 64'(busy[0]), 64'd0);
        enable = 1'b1; repeat (3) tick();
        chk("abort_no_restart", 64'(busy[0]), 64'd0);
        chk("abort_cnt", 64'(cnt_of(0)), 64'(cnt_m[0]));
        req[0] = 1'b0; tick();

        // rise with enable=0 is ignored
        enable = 1'b0; req[1] = 1'b1; tick();
        enable = 1'b1; tick(); tick();
        chk("dis_rise_ignored", 64'(busy[1]), 64'd0);
        req[1] = 1'b0; tick();

        // rst mid-handshake on ch2; held req after reset starts nothing
        req[2] = 1'b1; tick(); tick(); tick();
        chk("pre_rst_busy", 64'(busy[2]), 64'd1);
        rst = 1'b1; tick();
        chk("rst_mid_idle", 64'(busy[2]), 64'd0);
        rst = 1'b0; repeat (3) tick();
        for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_lat", 64'(last_lat), 64'd0);
        chk("post_rst_cnt", 64'(viol_cnt), 64'd0);
        chk("post_rst_any", 64'(any_viol), 64'd0);
        req = '0; repeat (3) tick();

        chk("pending_expected_flags", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
